// File: rtl/mem_data_unit_pkg.sv
// Shared definitions for the memory data unit: FSM state encoding and the
// default bus/address widths also used by the register file.
package mem_data_unit_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 9;
  localparam int unsigned DEF_TIMEOUT    = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } mdu_state_e;

endpackage : mem_data_unit_pkg

// File: rtl/mem_data_unit_wait.sv
// Wait-cycle counter for memory accesses.
// Ports:
//   clock   - clock, state changes on the falling edge
//   clear   - asynchronous active-low reset
//   start   - restart the count at 0 (asserted on the edge entering a wait state)
//   ack     - memory acknowledge; holds the count and masks expiry
//   expired - combinational: current wait cycle is the last allowed one and no ack
module mem_wait_counter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  // Count completed wait cycles; saturate so it never wraps while idle.
  always_ff @(negedge clock or negedge clear) begin
    if (!clear) begin
      r_count <= '0;
    end else if (start) begin
      r_count <= '0;
    end else if (!ack && (r_count != CW'(TIMEOUT))) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Wait cycle number TIMEOUT is running (count = TIMEOUT-1) with no ack:
  // the counter reaches TIMEOUT on this edge. An ack in that same cycle wins.
  assign expired = (r_count == CW'(TIMEOUT - 1)) && !ack;

endmodule : mem_wait_counter

// File: rtl/mem_data_unit.sv
// Memory data unit: MAR/MDR registers plus a small read/write handshake FSM
// towards a memory with a completion strobe and a wait-cycle timeout.
// Ports:
//   clock, clear        - falling-edge clock, async active-low reset
//   BusMuxOut           - internal bus value, source for MAR/MDR loads
//   MARin, MDRin        - load MAR / MDR (honoured in IDLE only)
//   Read, Write         - one-cycle access requests (Read wins on conflict)
//   MDRout              - MDR contents to the bus mux
//   busy, done, err     - status: not idle, completion pulse, sticky timeout
//   mem_req, mem_we     - memory request / write enable (registered)
//   mem_addr, mem_wdata - MAR and MDR driven to memory
//   mem_rdata, mem_ack  - memory read data and completion strobe
module mem_data_unit
  import mem_data_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic                  MARin,
  input  logic                  MDRin,
  input  logic                  Read,
  input  logic                  Write,
  output logic [DATA_WIDTH-1:0] MDRout,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  mdu_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_mar;
  logic [DATA_WIDTH-1:0] r_mdr;
  logic                  r_done;
  logic                  r_err;
  logic                  r_mem_req;
  logic                  r_mem_we;

  logic                  w_start;
  logic                  w_expired;

  // A request accepted in IDLE restarts the wait counter.
  assign w_start = (r_state == ST_IDLE) && (Read || Write);

  mem_wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait (
    .clock   (clock),
    .clear   (clear),
    .start   (w_start),
    .ack     (mem_ack),
    .expired (w_expired)
  );

  // Access FSM with MAR/MDR and registered handshake outputs.
  always_ff @(negedge clock or negedge clear) begin
    if (!clear) begin
      r_state   <= ST_IDLE;
      r_mar     <= '0;
      r_mdr     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Loads land on the same edge as the request, so the access
          // sees the freshly loaded address/data.
          if (MARin) r_mar <= BusMuxOut[ADDR_WIDTH-1:0];
          if (MDRin) r_mdr <= BusMuxOut;
          if (Read) begin
            r_state   <= ST_RD_WAIT;
            r_err     <= 1'b0;
            r_mem_req <= 1'b1;
            r_mem_we  <= 1'b0;
          end else if (Write) begin
            r_state   <= ST_WR_WAIT;
            r_err     <= 1'b0;
            r_mem_req <= 1'b1;
            r_mem_we  <= 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (mem_ack) begin
            r_mdr     <= mem_rdata;
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end else if (w_expired) begin
            r_state   <= ST_IDLE;
            r_err     <= 1'b1;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        ST_WR_WAIT: begin
          if (mem_ack) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end else if (w_expired) begin
            r_state   <= ST_IDLE;
            r_err     <= 1'b1;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mar;
  assign mem_wdata = r_mdr;
  assign MDRout    = r_mdr;

endmodule : mem_data_unit

// File: tb/tb_mem_data_unit.sv
// Directed bench for mem_data_unit: read, write, timeout, timeout-boundary
// ack, request conflict, busy-time loads and mid-access reset.
module tb_mem_data_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;

  logic          clock;
  logic          clear;
  logic [DW-1:0] BusMuxOut;
  logic          MARin, MDRin, Read, Write;
  logic [DW-1:0] MDRout;
  logic          busy, done, err, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  int n_checks = 0;
  int n_errors = 0;

  mem_data_unit #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (15)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .BusMuxOut (BusMuxOut),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .Read      (Read),
    .Write     (Write),
    .MDRout    (MDRout),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One falling (active) edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clear = 1'b0; BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
    mem_rdata = '0; mem_ack = 0;

    // Reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_mdr", MDRout, 0);
    tick();
    clear = 1'b1;
    tick();

    // Read: MAR=0x05, ack on 3rd wait cycle
    BusMuxOut = 32'h5; MARin = 1; tick(); MARin = 0;
    Read = 1; tick(); Read = 0;
    chk("rd_req", mem_req, 1);
    chk("rd_we", mem_we, 0);
    chk("rd_addr", mem_addr, 9'h005);
    chk("rd_busy", busy, 1);
    tick();
    chk("rd_w2_done", done, 0);
    tick();
    mem_rdata = 32'hDEADBEEF; mem_ack = 1; tick(); mem_ack = 0;
    chk("rd_done", done, 1);
    chk("rd_mdr", MDRout, 32'hDEADBEEF);
    chk("rd_req_off", mem_req, 0);
    tick();
    chk("rd_done_pulse", done, 0);
    chk("rd_idle", busy, 0);

    // Write: MDR=0x12345678, MAR=0x1FF, ack on 1st wait cycle
    BusMuxOut = 32'h12345678; MDRin = 1; tick(); MDRin = 0;
    BusMuxOut = 32'h000001FF; MARin = 1; tick(); MARin = 0;
    Write = 1; tick(); Write = 0;
    chk("wr_req", mem_req, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 9'h1FF);
    chk("wr_wdata", mem_wdata, 32'h12345678);
    chk("wr_w1_done", done, 0);
    mem_rdata = 32'hCAFEF00D; mem_ack = 1; tick(); mem_ack = 0;
    chk("wr_done", done, 1);
    chk("wr_mdr_keep", MDRout, 32'h12345678);
    chk("wr_we_off", mem_we, 0);
    tick();

    // Timeout: read, no ack for 15 wait cycles
    Read = 1; tick(); Read = 0;
    ticks(14);
    chk("to_w15_busy", busy, 1);
    chk("to_w15_err", err, 0);
    tick();
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_done", done, 0);
    chk("to_req", mem_req, 0);
    chk("to_mdr", MDRout, 32'h12345678);
    tick();
    chk("to_err_sticky", err, 1);
    Read = 1; tick(); Read = 0;
    chk("to_err_clr", err, 0);
    mem_rdata = 32'hA5A5A5A5; mem_ack = 1; tick(); mem_ack = 0;
    chk("to_rd2_mdr", MDRout, 32'hA5A5A5A5);
    tick();

    // Ack on the 15th wait cycle completes normally
    Read = 1; tick(); Read = 0;
    ticks(14);
    mem_rdata = 32'h11112222; mem_ack = 1; tick(); mem_ack = 0;
    chk("edge_done", done, 1);
    chk("edge_err", err, 0);
    chk("edge_mdr", MDRout, 32'h11112222);
    tick();

    // Conflict: Read and Write together; loads ignored while busy
    Read = 1; Write = 1; tick(); Read = 0; Write = 0;
    chk("cf_req", mem_req, 1);
    chk("cf_we", mem_we, 0);
    BusMuxOut = 32'hFFFF0000; MARin = 1; MDRin = 1; tick(); MARin = 0; MDRin = 0;
    chk("cf_mar_keep", mem_addr, 9'h1FF);
    chk("cf_mdr_keep", MDRout, 32'h11112222);
    mem_rdata = 32'h0BADF00D; mem_ack = 1; tick(); mem_ack = 0;
    chk("cf_done", done, 1);
    chk("cf_mdr", MDRout, 32'h0BADF00D);
    // Read in DONE is dropped
    Read = 1; tick(); Read = 0;
    chk("dn_rd_busy", busy, 0);
    chk("dn_rd_req", mem_req, 0);

    // Reset during the 2nd wait cycle, then a late ack
    Write = 1; tick(); Write = 0;
    tick();
    chk("rs_pre_req", mem_req, 1);
    clear = 1'b0;
    #1;
    chk("rs_req", mem_req, 0);
    chk("rs_we", mem_we, 0);
    chk("rs_busy", busy, 0);
    chk("rs_addr", mem_addr, 0);
    chk("rs_mdr", MDRout, 0);
    chk("rs_err", err, 0);
    clear = 1'b1;
    mem_rdata = 32'h77777777; mem_ack = 1; tick(); mem_ack = 0;
    chk("rs_ack_busy", busy, 0);
    chk("rs_ack_done", done, 0);
    chk("rs_ack_mdr", MDRout, 0);
    chk("rs_ack_req", mem_req, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_mem_data_unit

// File: doc/mem_data_unit.md
MEM_DATA_UNIT -- requirements
Module: mem_data_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus and memory data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, MAR and memory address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, the maximum number of wait cycles for mem_ack.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on the falling edge.
REQ-005 SHALL have port clear, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port BusMuxOut, input, DATA_WIDTH, internal bus value.
REQ-007 SHALL have port MARin, input, 1, load MAR from BusMuxOut[ADDR_WIDTH-1:0].
REQ-008 SHALL have port MDRin, input, 1, load MDR from BusMuxOut.
REQ-009 SHALL have port Read, input, 1, a 1-cycle request to start a memory read.
REQ-010 SHALL have port Write, input, 1, a 1-cycle request to start a memory write.
REQ-011 SHALL have port MDRout, output, DATA_WIDTH, current MDR contents to the bus mux.
REQ-012 SHALL have port busy, output, 1, high when not IDLE.
REQ-013 SHALL have port done, output, 1, a 1-cycle completion pulse.
REQ-014 SHALL have port err, output, 1, sticky timeout flag.
REQ-015 SHALL have port mem_req, output, 1, memory request.
REQ-016 SHALL have port mem_we, output, 1, high for a write, low for a read.
REQ-017 SHALL have port mem_addr, output, ADDR_WIDTH, equal to MAR.
REQ-018 SHALL have port mem_wdata, output, DATA_WIDTH, equal to MDR.
REQ-019 SHALL have port mem_rdata, input, DATA_WIDTH, read data, valid with mem_ack.
REQ-020 SHALL have port mem_ack, input, 1, memory completion strobe.

Function
REQ-021 SHALL implement the states IDLE, RD_WAIT, WR_WAIT and DONE.
REQ-022 In IDLE, MARin and MDRin SHALL load on the clock edge; both may load in the same cycle; outside IDLE both SHALL be ignored.
REQ-023 In IDLE, Read SHALL move to RD_WAIT; Write SHALL move to WR_WAIT; if both are high, Read SHALL win and Write SHALL be dropped.
REQ-024 A Read or Write accepted in IDLE SHALL clear err; MARin or MDRin in the same cycle SHALL load first, so the request uses the new values.
REQ-025 mem_req SHALL be registered and high exactly in RD_WAIT and WR_WAIT; mem_we SHALL be high only in WR_WAIT.
REQ-026 In RD_WAIT with mem_ack high: MDR SHALL load mem_rdata and the state SHALL move to DONE.
REQ-027 In WR_WAIT with mem_ack high: MDR SHALL be unchanged and the state SHALL move to DONE.
REQ-028 Wait counter: SHALL reset to 0 on entry to a wait state and increment each wait cycle without ack.
REQ-029 Wait counter: when it reaches TIMEOUT without ack, SHALL set err, leave MDR unchanged and return to IDLE, with no done pulse.
REQ-030 Wait counter: an ack in the same cycle as the counter reaching TIMEOUT SHALL complete normally.
REQ-031 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-032 Read/Write in DONE SHALL be ignored.
REQ-033 mem_ack SHALL be ignored in IDLE and DONE.
REQ-034 Minimum latency, request to done, SHALL be 2 cycles (ack on the first wait cycle).
REQ-035 MDRout SHALL be the MDR register directly, with no extra cycle.
REQ-036 busy SHALL be combinational from the state.

Reset
REQ-037 clear low SHALL immediately force IDLE, and set MAR=0, MDR=0, counter=0, err=0, done=0, mem_req=0, mem_we=0, independent of clock.
REQ-038 Reset mid-transaction SHALL abandon the access; a late mem_ack after release SHALL be ignored.

Structure
REQ-039 A shared package SHALL hold the state enum, plus the DATA_WIDTH and ADDR_WIDTH defaults shared with the register file.
REQ-040 The wait counter SHALL be one sub-module, mem_wait_counter (clear, clock, start, ack, expired).
REQ-041 The MAR and MDR SHALL be local registers, not external register instances.

Verification
REQ-042 Read: MARin with bus=0x05, then Read; ack on the 3rd wait cycle with rdata=0xDEADBEEF -> mem_addr=0x05, mem_we=0, done pulse, MDRout=0xDEADBEEF.
REQ-043 Write: MDRin with bus=0x12345678, MARin with bus=0x1FF, then Write; ack on the 1st wait cycle -> mem_we=1, wdata=0x12345678, done 2 cycles after Write.
REQ-044 Timeout: Read with no ack and TIMEOUT=15 -> err=1 after 15 wait cycles, no done, MDR unchanged; the next Read clears err.
REQ-045 Conflict: Read and Write in the same cycle -> read performed; MDRin and MARin during busy -> no change.
REQ-046 Reset: clear low in the 2nd wait cycle -> mem_req drops immediately, all outputs 0; ack after release -> no state change.
